// File: rtl/atom_decimator_10x_if.sv
// atom_decimator_10x_if
//   Sample-stream bundle for the 10x decimator.
//   master : sample source / result consumer (drives in_valid, in_sample)
//   slave  : decimator (drives in_ready, out_valid, out_sample)
//   in_valid   1  input sample offered
//   in_ready   1  decimator can accept a sample
//   in_sample  8  signed input sample
//   out_valid  1  one-cycle pulse, out_sample updated
//   out_sample 8  signed decimated sample, held until next out_valid
interface atom_decimator_10x_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_sample;
  logic       out_valid;
  logic [7:0] out_sample;

  modport master (
    output in_valid, in_sample,
    input  in_ready, out_valid, out_sample
  );

  modport slave (
    input  in_valid, in_sample,
    output in_ready, out_valid, out_sample
  );
endinterface

// File: rtl/atom_decimator_10x.sv
// atom_decimator_10x
//   10-tap FIR with 10x decimation. Each accepted 8-bit signed sample is
//   multiplied bit-serially (LSB first, MSB weight subtracted) by the tap for
//   the current phase over 8 cycles, then added into a 20-bit accumulator.
//   After tap 9 the accumulator is scaled by >>>7 and emitted as one 8-bit
//   signed sample.
// Parameters
//   COEFS   packed signed Q0.7 taps, tap k = COEFS[8k+7:8k], k = 0..9
// Ports
//   clk      clock, all logic on posedge
//   reset_n  asynchronous active-low reset
//   sync     realign: clear tap phase and accumulator
//   bus      sample stream (slave side of atom_decimator_10x_if)
//   phase    index of the next tap to apply, 0..9
// Configuration
//   DECIM_SAT_EN  defined: clamp result to [-128,127]; undefined: wrap to 8 bits
module atom_decimator_10x #(
  parameter logic [79:0] COEFS = 80'h0D0D0D0D0D0D0D0D0D0D
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync,
  atom_decimator_10x_if.slave  bus,
  output logic [3:0]           phase
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACC} state_t;

  state_t             state_q;
  logic        [7:0]  shift_q;
  logic        [7:0]  coef_q;
  logic        [15:0] prod_q;
  logic        [2:0]  bit_q;
  logic signed [19:0] acc_q;
  logic        [3:0]  phase_q;
  logic               sync_pend_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic        [7:0]  out_sample_q;

  logic        [7:0]  tap_sel;
  logic        [15:0] coef_sh;
  logic        [15:0] prod_d;
  logic signed [19:0] acc_d;
  logic        [7:0]  result;

  // A sync coinciding with an accept forces tap 0 for that sample.
  always_comb begin
    tap_sel = '0;
    for (int unsigned k = 0; k < 10; k++) begin
      if ((sync ? 4'd0 : phase_q) == k[3:0]) tap_sel = COEFS[8*k +: 8];
    end
  end

  // One partial product per cycle; bit 7 carries negative weight.
  always_comb begin
    coef_sh = {{8{coef_q[7]}}, coef_q} << bit_q;
    prod_d  = prod_q;
    if (shift_q[0]) prod_d = (bit_q == 3'd7) ? prod_q - coef_sh : prod_q + coef_sh;
  end

  assign acc_d = acc_q + {{4{prod_q[15]}}, prod_q};

`ifdef DECIM_SAT_EN
  logic signed [12:0] res_full;
  always_comb begin
    res_full = acc_d[19:7];
    if (res_full > 13'sd127)       result = 8'h7F;
    else if (res_full < -13'sd128) result = 8'h80;
    else                           result = res_full[7:0];
  end
`else
  assign result = acc_d[14:7];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      coef_q       <= '0;
      prod_q       <= '0;
      bit_q        <= '0;
      acc_q        <= '0;
      phase_q      <= '0;
      sync_pend_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sync) begin
            phase_q <= '0;
            acc_q   <= '0;
          end
          if (bus.in_valid) begin
            shift_q    <= bus.in_sample;
            coef_q     <= tap_sel;
            prod_q     <= '0;
            bit_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_MAC;
          end
        end
        S_MAC: begin
          if (sync) sync_pend_q <= 1'b1;
          prod_q  <= prod_d;
          shift_q <= shift_q >> 1;
          bit_q   <= bit_q + 3'd1;
          if (bit_q == 3'd7) state_q <= S_ACC;
        end
        S_ACC: begin
          // A sync seen during this operation drops its product entirely.
          if (sync || sync_pend_q) begin
            acc_q       <= '0;
            phase_q     <= '0;
            sync_pend_q <= 1'b0;
          end else if (phase_q == 4'd9) begin
            acc_q        <= '0;
            phase_q      <= '0;
            out_sample_q <= result;
            out_valid_q  <= 1'b1;
          end else begin
            acc_q   <= acc_d;
            phase_q <= phase_q + 4'd1;
          end
          in_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sample = out_sample_q;
  assign phase          = phase_q;

endmodule

// File: tb/tb_atom_decimator_10x.sv
module tb_atom_decimator_10x;

`ifdef DECIM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [2:0] iv, rdy, ov, sy;
  logic [7:0] smp  [3];
  logic [7:0] osmp [3];
  logic [3:0] ph   [3];

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] q0[$], q1[$], q2[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  atom_decimator_10x_if ifa ();
  atom_decimator_10x_if ifb ();
  atom_decimator_10x_if ifc ();

  assign ifa.in_valid = iv[0]; assign ifa.in_sample = smp[0];
  assign ifb.in_valid = iv[1]; assign ifb.in_sample = smp[1];
  assign ifc.in_valid = iv[2]; assign ifc.in_sample = smp[2];
  assign rdy[0] = ifa.in_ready; assign ov[0] = ifa.out_valid; assign osmp[0] = ifa.out_sample;
  assign rdy[1] = ifb.in_ready; assign ov[1] = ifb.out_valid; assign osmp[1] = ifb.out_sample;
  assign rdy[2] = ifc.in_ready; assign ov[2] = ifc.out_valid; assign osmp[2] = ifc.out_sample;

  atom_decimator_10x u_a (
    .clk(clk), .reset_n(reset_n), .sync(sy[0]), .bus(ifa), .phase(ph[0]));
  atom_decimator_10x #(.COEFS(80'h0000_0000_0000_4000_0000)) u_b (
    .clk(clk), .reset_n(reset_n), .sync(sy[1]), .bus(ifb), .phase(ph[1]));
  atom_decimator_10x #(.COEFS(80'h7F7F_7F7F_7F7F_7F7F_7F7F)) u_c (
    .clk(clk), .reset_n(reset_n), .sync(sy[2]), .bus(ifc), .phase(ph[2]));

  typedef struct {
    int         sel;
    int         val;
    int         hot;   // -1: every phase gets val; else only that phase
    logic [7:0] exp;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [7:0] e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic int pop(input int i);
    case (i)
      0: return int'(q0.pop_front());
      1: return int'(q1.pop_front());
      default: return int'(q2.pop_front());
    endcase
  endfunction

  task automatic wait_ready(input int sel);
    int n = 0;
    @(negedge clk);
    while (!rdy[sel] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[sel]) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input int sel, input logic [7:0] v, input logic s);
    wait_ready(sel);
    iv[sel]  = 1'b1;
    smp[sel] = v;
    sy[sel]  = s;
    @(posedge clk);
    #1;
    iv[sel] = 1'b0;
    sy[sel] = 1'b0;
  endtask

  task automatic run_block(input int sel, input int val, input int hot, input logic [7:0] exp);
    int v;
    for (int k = 0; k < 10; k++) begin
      v = (hot < 0 || k == hot) ? val : 0;
      send(sel, v[7:0], 1'b0);
      if (k == 9) push(sel, exp);
      wait_ready(sel);
      chk("phase_step", int'(ph[sel]), (k + 1) % 10);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((qsize(0) + qsize(1) + qsize(2)) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", qsize(0) + qsize(1) + qsize(2), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] prev [3];
    int acc_n, last, lowrun;

    vt[0] = '{sel: 0, val: 100,  hot: -1, exp: 8'h65};
    vt[1] = '{sel: 1, val: 127,  hot: 3,  exp: 8'h3F};
    vt[2] = '{sel: 2, val: 127,  hot: -1, exp: SAT ? 8'h7F : 8'hEC};
    vt[3] = '{sel: 2, val: -128, hot: -1, exp: SAT ? 8'h80 : 8'h0A};
    vt[4] = '{sel: 0, val: -50,  hot: -1, exp: 8'hCD};
    vt[5] = '{sel: 1, val: -128, hot: 3,  exp: 8'hC0};
    vt[6] = '{sel: 0, val: 0,    hot: -1, exp: 8'h00};

    reset_n = 1'b0;
    iv = '0;
    sy = '0;
    for (int i = 0; i < 3; i++) begin
      smp[i]  = '0;
      prev[i] = 2'b00;
    end

    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          if (ov[i]) begin
            // out_valid must land in the cycle in_ready rises
            chk("out_with_ready_rise", int'({prev[i][0], rdy[i]}), 1);
            if (qsize(i) == 0) chk("unexpected_out_valid", 1, 0);
            else chk("out_sample", int'(osmp[i]), pop(i));
          end
          prev[i][0] = rdy[i];
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready",   int'(rdy[0]), 1);
    chk("reset_out_valid",  int'(ov[0]), 0);
    chk("reset_out_sample", int'(osmp[0]), 0);
    chk("reset_phase",      int'(ph[0]), 0);
    #1 reset_n = 1'b1;

    for (int t = 0; t < 7; t++) begin
      run_block(vt[t].sel, vt[t].val, vt[t].hot, vt[t].exp);
      drain();
    end

    // continuous in_valid: one accept every 10 clk, in_ready low 9 clk
    wait_ready(0);
    iv[0]  = 1'b1;
    smp[0] = 8'd100;
    acc_n  = 0;
    last   = -1;
    lowrun = 0;
    for (int c = 0; c < 300 && acc_n < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (rdy[0]) begin
        if (lowrun > 0) chk("ready_low_run", lowrun, 9);
        lowrun = 0;
        if (last >= 0) chk("accept_spacing", c - last, 10);
        last = c;
        acc_n++;
        if (acc_n % 10 == 0) push(0, 8'h65);
      end else begin
        lowrun++;
      end
    end
    chk("continuous_accepts", acc_n, 20);
    @(posedge clk);
    #1 iv[0] = 1'b0;
    drain();

    // sync in IDLE after 4 samples
    for (int k = 0; k < 4; k++) send(0, 8'd100, 1'b0);
    wait_ready(0);
    chk("pre_sync_phase", int'(ph[0]), 4);
    sy[0] = 1'b1;
    @(negedge clk);
    sy[0] = 1'b0;
    chk("sync_idle_phase", int'(ph[0]), 0);
    run_block(0, 100, -1, 8'h65);
    drain();

    // sync during MAC discards that tap
    for (int k = 0; k < 4; k++) send(0, 8'd100, 1'b0);
    repeat (2) @(posedge clk);
    #1 sy[0] = 1'b1;
    @(posedge clk);
    #1 sy[0] = 1'b0;
    wait_ready(0);
    chk("sync_mac_phase", int'(ph[0]), 0);
    run_block(0, 100, -1, 8'h65);
    drain();

    // sync together with accept: that sample uses tap 0
    for (int k = 0; k < 3; k++) send(1, 8'd0, 1'b0);
    send(1, 8'd127, 1'b1);
    wait_ready(1);
    chk("sync_accept_phase", int'(ph[1]), 1);
    for (int k = 1; k < 10; k++) begin
      send(1, (k == 3) ? 8'd127 : 8'd0, 1'b0);
      if (k == 9) push(1, 8'h3F);
    end
    drain();

    // reset at MAC bit 4
    for (int k = 0; k < 5; k++) send(0, 8'd100, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready",   int'(rdy[0]), 1);
    chk("abort_phase",      int'(ph[0]), 0);
    chk("abort_out_sample", int'(osmp[0]), 0);
    run_block(0, 100, -1, 8'h65);
    drain();

    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
